// File: rtl/arb16b4.sv
// arb16b4: 4-way round-robin arbiter feeding a registered 16-bit output stage.
// Ports: clk, rst_n (sync, active-low), req_valid/req_data0..3/req_ready (sources),
//   out_valid/out_data/out_src/out_ready (sink), req_lock (only with ARB16B4_LOCK_EN).
// Build option: define ARB16B4_LOCK_EN for grant retention via req_lock.

module mux16b4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  s,
  output logic [15:0] y
);

  always_comb begin
    y = a;
    unique case (s)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

module arb16b4 #(
  parameter logic [1:0] RESET_PTR = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  input  logic [15:0] req_data2,
  input  logic [15:0] req_data3,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [1:0]  out_src,
  input  logic        out_ready
`ifdef ARB16B4_LOCK_EN
  ,
  input  logic [3:0]  req_lock
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  src_q, src_d;

  logic [3:0]  elig;
  logic [1:0]  sel;
  logic        found;
  logic        free;
  logic        grant;
  logic [15:0] mux_y;

`ifdef ARB16B4_LOCK_EN
  logic        locked_q, locked_d;
  logic [1:0]  lock_idx_q, lock_idx_d;

  // While locked only the holder is eligible.
  always_comb begin
    elig = req_valid;
    if (locked_q) begin
      elig = req_valid & (4'b0001 << lock_idx_q);
    end
  end
`else
  always_comb begin
    elig = req_valid;
  end
`endif

  // Scan ptr+1, ptr+2, ptr+3, ptr; first eligible wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign free  = (state_q == EMPTY) || out_ready;
  assign grant = free && found && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[sel] = 1'b1;
    end
  end

  mux16b4 u_mux (
    .a (req_data0),
    .b (req_data1),
    .c (req_data2),
    .d (req_data3),
    .s (sel),
    .y (mux_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (grant) begin
      state_d = FULL;
      ptr_d   = sel;
      data_d  = mux_y;
      src_d   = sel;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

`ifdef ARB16B4_LOCK_EN
  // A vanished holder releases the lock only when it could have been served.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (grant) begin
      locked_d   = req_lock[sel];
      lock_idx_d = sel;
    end else if (locked_q && free && !req_valid[lock_idx_q]) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      lock_idx_q <= 2'd0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= RESET_PTR;
      data_q  <= 16'h0000;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule
